// File: rtl/lcd_pkg.sv
// Shared LCD definitions: HD44780 command bytes, operator character codes
// used by the switch stage, and the writer FSM state/phase encodings.
package lcd_pkg;

  localparam logic [7:0] LCD_CMD_FUNC_SET   = 8'h38;
  localparam logic [7:0] LCD_CMD_DISP_ON    = 8'h0C;
  localparam logic [7:0] LCD_CMD_ENTRY_MODE = 8'h06;
  localparam logic [7:0] LCD_CMD_CLEAR      = 8'h01;
  localparam logic [7:0] LCD_CMD_SET_DDRAM  = 8'h80;

  localparam logic [7:0] CHR_BLANK  = 8'h20;
  localparam logic [7:0] CHR_PLUS   = 8'h2B;
  localparam logic [7:0] CHR_MINUS  = 8'h2D;
  localparam logic [7:0] CHR_TIMES  = 8'hD7;
  localparam logic [7:0] CHR_DIVIDE = 8'hFD;

  typedef enum logic [2:0] {
    ST_PWR,
    ST_INIT,
    ST_CLR_DLY,
    ST_IDLE,
    ST_WR_POS,
    ST_WR_CHR
  } lcd_state_e;

  typedef enum logic [1:0] {
    PH_SETUP,
    PH_STROBE,
    PH_HOLD
  } bus_phase_e;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    init_cmd = LCD_CMD_FUNC_SET;
      2'd1:    init_cmd = LCD_CMD_DISP_ON;
      2'd2:    init_cmd = LCD_CMD_ENTRY_MODE;
      default: init_cmd = LCD_CMD_CLEAR;
    endcase
  endfunction

  function automatic bus_phase_e next_phase(input bus_phase_e ph);
    case (ph)
      PH_SETUP:  next_phase = PH_STROBE;
      PH_STROBE: next_phase = PH_HOLD;
      default:   next_phase = PH_SETUP;
    endcase
  endfunction

endpackage

// File: rtl/lcd_op_writer_if.sv
// Operator-character input plus LCD write-bus outputs of the writer.
interface lcd_op_writer_if;
  logic [7:0] i_char;
  logic       o_lcd_e;
  logic       o_lcd_rs;
  logic       o_lcd_rw;
  logic [7:0] o_lcd_data;
  logic       o_ready;

  modport master (
    output i_char,
    input  o_lcd_e, o_lcd_rs, o_lcd_rw, o_lcd_data, o_ready
  );

  modport slave (
    input  i_char,
    output o_lcd_e, o_lcd_rs, o_lcd_rw, o_lcd_data, o_ready
  );
endinterface

// File: rtl/lcd_tick_gen.sv
// Free-running divider: one-clk o_tick pulse every TICK_DIV clk cycles.
module lcd_tick_gen #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic o_tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    o_tick = (cnt_q == CNT_LAST);
    cnt_d  = o_tick ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/lcd_op_writer.sv
// Initialises an HD44780-style LCD, then rewrites the operator character at
// DISP_ADDR whenever i_char differs from the character last written.
module lcd_op_writer
  import lcd_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 50000,
  parameter int unsigned PWR_WAIT  = 20,
  parameter int unsigned CLR_WAIT  = 2,
  parameter logic [6:0]  DISP_ADDR = 7'h0F
) (
  input logic           clk,
  input logic           rst,
  lcd_op_writer_if.slave bus
);

  localparam int unsigned WAIT_MAX = (PWR_WAIT > CLR_WAIT) ? PWR_WAIT : CLR_WAIT;
  localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] PWR_LAST = WAIT_W'(PWR_WAIT - 1);
  localparam logic [WAIT_W-1:0] CLR_LAST = WAIT_W'(CLR_WAIT - 1);

  logic tick;

  lcd_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .o_tick (tick)
  );

  lcd_state_e        state_q,    state_d;
  bus_phase_e        phase_q,    phase_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [1:0]        init_idx_q, init_idx_d;
  logic [7:0]        pending_q,  pending_d;
  logic [7:0]        last_chr_q, last_chr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_PWR;
      phase_q    <= PH_SETUP;
      wait_cnt_q <= '0;
      init_idx_q <= '0;
      pending_q  <= CHR_BLANK;
      last_chr_q <= CHR_BLANK;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      wait_cnt_q <= wait_cnt_d;
      init_idx_q <= init_idx_d;
      pending_q  <= pending_d;
      last_chr_q <= last_chr_d;
    end
  end

  // Bus-cycle states step SETUP->STROBE->HOLD on ticks; HOLD wraps to SETUP,
  // so every bus state is entered with the phase already at SETUP.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    wait_cnt_d = wait_cnt_q;
    init_idx_d = init_idx_q;
    pending_d  = pending_q;
    last_chr_d = last_chr_q;
    case (state_q)
      ST_PWR: begin
        if (tick) begin
          if (wait_cnt_q == PWR_LAST) begin
            wait_cnt_d = '0;
            init_idx_d = '0;
            phase_d    = PH_SETUP;
            state_d    = ST_INIT;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end
      end
      ST_INIT: begin
        if (tick) begin
          phase_d = next_phase(phase_q);
          if (phase_q == PH_HOLD) begin
            if (init_idx_q == 2'd3) state_d    = ST_CLR_DLY;
            else                    init_idx_d = init_idx_q + 2'd1;
          end
        end
      end
      ST_CLR_DLY: begin
        if (tick) begin
          if (wait_cnt_q == CLR_LAST) begin
            wait_cnt_d = '0;
            state_d    = ST_IDLE;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end
      end
      ST_IDLE: begin
        if (bus.i_char != last_chr_q) begin
          pending_d = bus.i_char;
          phase_d   = PH_SETUP;
          state_d   = ST_WR_POS;
        end
      end
      ST_WR_POS: begin
        if (tick) begin
          phase_d = next_phase(phase_q);
          if (phase_q == PH_HOLD) state_d = ST_WR_CHR;
        end
      end
      ST_WR_CHR: begin
        if (tick) begin
          phase_d = next_phase(phase_q);
          if (phase_q == PH_HOLD) begin
            last_chr_d = pending_q;
            state_d    = ST_IDLE;
          end
        end
      end
      default: state_d = ST_PWR;
    endcase
  end

  always_comb begin
    bus.o_lcd_e    = 1'b0;
    bus.o_lcd_rs   = 1'b0;
    bus.o_lcd_rw   = 1'b0;
    bus.o_lcd_data = '0;
    bus.o_ready    = 1'b0;
    case (state_q)
      ST_INIT: begin
        bus.o_lcd_data = init_cmd(init_idx_q);
        bus.o_lcd_e    = (phase_q == PH_STROBE);
      end
      ST_WR_POS: begin
        bus.o_lcd_data = LCD_CMD_SET_DDRAM | {1'b0, DISP_ADDR};
        bus.o_lcd_e    = (phase_q == PH_STROBE);
      end
      ST_WR_CHR: begin
        bus.o_lcd_rs   = 1'b1;
        bus.o_lcd_data = pending_q;
        bus.o_lcd_e    = (phase_q == PH_STROBE);
      end
      ST_IDLE: bus.o_ready = (bus.i_char == last_chr_q);
      default: ;
    endcase
  end

endmodule
